kr580vv55_ppi: RTL

KR580VV55_PPI -- requirements
Module: kr580vv55_ppi

---
 rtl/kr580vv55_ppi_if.sv | 13 +
 rtl/kr580vv55_ppi.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/kr580vv55_ppi_if.sv
// kr580vv55_ppi_if: CPU-side I/O bus of the PPI (address, strobes, write data, read data).
// Ports: port  - CPU I/O address (master -> slave)
//        port_we - one-ce write strobe, port_rd - one-ce read strobe
//        din   - write data (master -> slave), dout - read data (slave -> master)
interface kr580vv55_ppi_if;
   logic [7:0] port;
   logic       port_we;
   logic       port_rd;
   logic [7:0] din;
   logic [7:0] dout;
   modport master (output port, port_we, port_rd, din, input dout);
   modport slave (input port, port_we, port_rd, din, output dout);
endinterface

// File: rtl/kr580vv55_ppi.sv
// kr580vv55_ppi: 8255-style PPI with mode 0 and mode 1 (strobed handshake) on groups A and B.
// Ports: clock/reset/ce - clock, async active-high reset, clock enable
//        bus     - CPU I/O bus (slave side), decoded at BASE[7:2]:00..11 (PA, PB, PC, CTRL)
//        pa_i/pb_i/pc_i - pin inputs; pa_o/pb_o/pc_o - pin output values
//        pa_oe/pb_oe    - port drive enables; pc_oe - per-bit PC drive enable
//        intr_a/intr_b  - INTR_A (PC3) and INTR_B (PC0)
module kr580vv55_ppi #(
   parameter logic [7:0] BASE = 8'h00
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  ce,
   kr580vv55_ppi_if.slave        bus,
   input  logic [7:0]            pa_i,
   input  logic [7:0]            pb_i,
   input  logic [7:0]            pc_i,
   output logic [7:0]            pa_o,
   output logic [7:0]            pb_o,
   output logic [7:0]            pc_o,
   output logic                  pa_oe,
   output logic                  pb_oe,
   output logic [7:0]            pc_oe,
   output logic                  intr_a,
   output logic                  intr_b
);
   logic [7:0] ctrl_q, ctrl_d, pa_q, pa_d, pb_q, pb_d, pc_q, pc_d, ina_q, ina_d, inb_q, inb_d;
   logic       ibf_a_q, ibf_a_d, obf_a_n_q, obf_a_n_d, intr_a_q, intr_a_d, inte_a_q, inte_a_d;
   logic       ibf_b_q, ibf_b_d, obf_b_n_q, obf_b_n_d, intr_b_q, intr_b_d, inte_b_q, inte_b_d;
   // handshake pin synchronizers, index 0 = PC2, 1 = PC4, 2 = PC6
   logic [2:0] s1_q, s2_q, prev_q, fall, rise;
   logic       cs, wr, rd, wr_pa, wr_pb, wr_pc, rd_pa, rd_pb, mset, bsr;
   logic [1:0] sel;
   logic [2:0] bit_n;
   logic       ma, a_in, cu_in, mb, b_in, cl_in, a_hin, a_hout;
   logic       a_fall, a_rise, bsr_inte_a, bsr_inte_b;
   logic [7:0] cm, om, st, pdir_out, pa_rd, pb_rd, pc_rd;
   assign cs    = bus.port[7:2] == BASE[7:2];
   assign sel   = bus.port[1:0];
   assign wr    = bus.port_we & cs;
   assign rd    = bus.port_rd & cs;
   assign wr_pa = wr & (sel == 2'd0);
   assign wr_pb = wr & (sel == 2'd1);
   assign wr_pc = wr & (sel == 2'd2);
   assign rd_pa = rd & (sel == 2'd0);
   assign rd_pb = rd & (sel == 2'd1);
   assign mset  = wr & (sel == 2'd3) & bus.din[7];
   assign bsr   = wr & (sel == 2'd3) & ~bus.din[7];
   assign bit_n = bus.din[3:1];
   assign ma      = |ctrl_q[6:5];
   assign a_in    = ctrl_q[4];
   assign cu_in   = ctrl_q[3];
   assign mb      = ctrl_q[2];
   assign b_in    = ctrl_q[1];
   assign cl_in   = ctrl_q[0];
   assign a_hin   = ma & a_in;
   assign a_hout  = ma & ~a_in;
   assign fall    = prev_q & ~s2_q;
   assign rise    = ~prev_q & s2_q;
   // group A listens to STB_A# (PC4) as input port, ACK_A# (PC6) as output port
   assign a_fall  = a_in ? fall[1] : fall[2];
   assign a_rise  = a_in ? rise[1] : rise[2];
   // BSR on the INTE bit of a mode 1 group updates INTE, not the PC latch
   assign bsr_inte_a = bsr & ma & (bit_n == (a_in ? 3'd4 : 3'd6));
   assign bsr_inte_b = bsr & mb & (bit_n == 3'd2);
   always_comb begin
      ctrl_d    = ctrl_q;
      pa_d      = wr_pa ? bus.din : pa_q;
      pb_d      = wr_pb ? bus.din : pb_q;
      pc_d      = wr_pc ? bus.din : pc_q;
      if (bsr & ~bsr_inte_a & ~bsr_inte_b)
         pc_d[bit_n] = bus.din[0];
      inte_a_d  = bsr_inte_a ? bus.din[0] : inte_a_q;
      inte_b_d  = bsr_inte_b ? bus.din[0] : inte_b_q;
      // strobe edge beats a same-cycle read, CPU write beats a same-cycle ACK edge,
      // and an INTR set beats an INTR clear
      ina_d     = (a_hin & a_fall) ? pa_i : ina_q;
      ibf_a_d   = (a_hin & a_fall) ? 1'b1 : (a_hin & rd_pa) ? 1'b0 : ibf_a_q;
      obf_a_n_d = (a_hout & wr_pa) ? 1'b0 : (a_hout & a_fall) ? 1'b1 : obf_a_n_q;
      intr_a_d  = (ma & a_rise) ? inte_a_q : (ma & (a_in ? rd_pa : wr_pa)) ? 1'b0 : intr_a_q;
      inb_d     = (mb & b_in & fall[0]) ? pb_i : inb_q;
      ibf_b_d   = (mb & b_in & fall[0]) ? 1'b1 : (mb & b_in & rd_pb) ? 1'b0 : ibf_b_q;
      obf_b_n_d = (mb & ~b_in & wr_pb) ? 1'b0 : (mb & ~b_in & fall[0]) ? 1'b1 : obf_b_n_q;
      intr_b_d  = (mb & rise[0]) ? inte_b_q : (mb & (b_in ? rd_pb : wr_pb)) ? 1'b0 : intr_b_q;
      if (mset) begin
         ctrl_d    = bus.din;
         pa_d      = 8'h00;
         pb_d      = 8'h00;
         pc_d      = 8'h00;
         inte_a_d  = 1'b0;
         inte_b_d  = 1'b0;
         intr_a_d  = 1'b0;
         intr_b_d  = 1'b0;
         ibf_a_d   = 1'b0;
         ibf_b_d   = 1'b0;
         obf_a_n_d = 1'b1;
         obf_b_n_d = 1'b1;
      end
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ctrl_q    <= 8'h9B;
         pa_q      <= 8'h00;
         pb_q      <= 8'h00;
         pc_q      <= 8'h00;
         ina_q     <= 8'h00;
         inb_q     <= 8'h00;
         ibf_a_q   <= 1'b0;
         ibf_b_q   <= 1'b0;
         obf_a_n_q <= 1'b1;
         obf_b_n_q <= 1'b1;
         intr_a_q  <= 1'b0;
         intr_b_q  <= 1'b0;
         inte_a_q  <= 1'b0;
         inte_b_q  <= 1'b0;
         s1_q      <= 3'b111;
         s2_q      <= 3'b111;
         prev_q    <= 3'b111;
      end else if (ce) begin
         ctrl_q    <= ctrl_d;
         pa_q      <= pa_d;
         pb_q      <= pb_d;
         pc_q      <= pc_d;
         ina_q     <= ina_d;
         inb_q     <= inb_d;
         ibf_a_q   <= ibf_a_d;
         ibf_b_q   <= ibf_b_d;
         obf_a_n_q <= obf_a_n_d;
         obf_b_n_q <= obf_b_n_d;
         intr_a_q  <= intr_a_d;
         intr_b_q  <= intr_b_d;
         inte_a_q  <= inte_a_d;
         inte_b_q  <= inte_b_d;
         s1_q      <= {pc_i[6], pc_i[4], pc_i[2]};
         s2_q      <= s1_q;
         prev_q    <= s2_q;
      end
   end
   // cm: PC bits claimed by a mode 1 group, om: claimed bits the PPI drives
   assign cm = {a_hout, a_hout, a_hin, a_hin, ma, mb, mb, mb};
   assign om = {a_hout, 1'b0, a_hin, 1'b0, ma, 1'b0, mb, 1'b0};
   assign st = {obf_a_n_q, inte_a_q, ibf_a_q, inte_a_q, intr_a_q, inte_b_q,
                b_in ? ibf_b_q : obf_b_n_q, intr_b_q};
   assign pdir_out = {{4{~cu_in}}, {4{~cl_in}}};
   assign pa_rd = a_in ? (ma ? ina_q : pa_i) : pa_q;
   assign pb_rd = b_in ? (mb ? inb_q : pb_i) : pb_q;
   assign pc_rd = (cm & st) | (~cm & ((pdir_out & pc_q) | (~pdir_out & pc_i)));
   assign bus.dout = ~cs ? 8'hFF : (sel == 2'd0) ? pa_rd : (sel == 2'd1) ? pb_rd :
                     (sel == 2'd2) ? pc_rd : ctrl_q;
   assign pa_o   = pa_q;
   assign pb_o   = pb_q;
   assign pc_o   = (cm & st) | (~cm & pc_q);
   assign pa_oe  = ~a_in;
   assign pb_oe  = ~b_in;
   assign pc_oe  = (~cm & pdir_out) | om;
   assign intr_a = intr_a_q;
   assign intr_b = intr_b_q;
endmodule
